led_pattern_seq: RTL and testbench

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

---
 rtl/led_pattern_seq.sv | 197 +++++++++++++++++++
 tb/tb_led_pattern_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: two-button LED pattern sequencer.
// A mode button cycles the display through binary, gray, walking-one and
// (optionally) bouncing-one patterns. A pause button freezes the step timer.
// Both buttons are synchronised and debounced internally.
// Optional feature macro: LED_PATTERN_SEQ_BOUNCE_EN (adds mode 3, bounce).
module led_pattern_seq #(
    parameter int WIDTH         = 16,
    parameter int LOG2DELAY     = 22,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BTN_MODE,
    input  logic             BTN_PAUSE,
    output logic [WIDTH-1:0] PAT,
    output logic [1:0]       MODE,
    output logic             PAUSED,
    output logic             TICK
);

    localparam int                       POSW      = $clog2(WIDTH);
    localparam logic [POSW-1:0]          POS_MAX   = POSW'(WIDTH - 1);
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX    = '1;
    localparam logic [LOG2DELAY-1:0]     PRESC_MAX = '1;
    localparam logic [WIDTH-1:0]         ONE_HOT0  = WIDTH'(1);

    // Button slot 0 is the mode button, slot 1 the pause button.
    localparam int BTN_IDX_MODE  = 0;
    localparam int BTN_IDX_PAUSE = 1;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    logic [1:0]               btnRaw;
    logic [1:0]               sync1_q;
    logic [1:0]               sync2_q;
    logic [1:0]               stable_q;
    logic [DEBOUNCE_BITS-1:0] dbCnt_q [2];
    logic [1:0]               press_d;

    mode_e                    mode_q;
    mode_e                    mode_d;
    logic                     paused_q;
    logic                     tick_q;
    logic [WIDTH-1:0]         pat_q;
    logic [WIDTH-1:0]         step_q;
    logic [WIDTH-1:0]         step_d;
    logic [POSW-1:0]          pos_q;
    logic [POSW-1:0]          pos_d;
    logic [LOG2DELAY-1:0]     presc_q;
    logic [WIDTH-1:0]         patStep_d;
    logic [WIDTH-1:0]         patLoad_d;
    logic                     wrap;
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
    logic                     dirDown_q;
    logic                     dirDown_d;
`endif

    assign btnRaw = {BTN_PAUSE, BTN_MODE};

    // Two-flop synchroniser, then a per-button counter that must see a
    // differing level for a full window before the stable level follows it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btnRaw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (dbCnt_q[i] == DB_MAX) begin
                    stable_q[i] <= sync2_q[i];
                    dbCnt_q[i]  <= '0;
                end else begin
                    dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A press is the cycle whose edge lifts a stable level from 0 to 1, so the
    // sequencer acts on the very edge the debounced level rises.
    always_comb begin
        press_d = '0;
        for (int i = 0; i < 2; i++) begin
            press_d[i] = sync2_q[i] & ~stable_q[i] & (dbCnt_q[i] == DB_MAX);
        end
    end

    assign wrap = !paused_q && (presc_q == PRESC_MAX);

    // Next step/position and the pattern to show after a timer step.
    always_comb begin
        step_d = step_q + 1'b1;
        pos_d  = pos_q;
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
        dirDown_d = dirDown_q;
`endif
        case (mode_q)
            MODE_WALK: pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
            MODE_BOUNCE: begin
                if (!dirDown_q) begin
                    if (pos_q == POS_MAX) begin
                        pos_d     = pos_q - 1'b1;
                        dirDown_d = 1'b1;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d     = pos_q + 1'b1;
                        dirDown_d = 1'b0;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
`endif
            default: pos_d = pos_q;
        endcase
        case (mode_q)
            MODE_BIN:  patStep_d = step_d;
            MODE_GRAY: patStep_d = step_d ^ (step_d >> 1);
            default:   patStep_d = ONE_HOT0 << pos_d;
        endcase
    end

    // Mode that a mode press selects and the pattern it starts from.
    always_comb begin
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
        mode_d = mode_e'(mode_q + 2'd1);
`else
        mode_d = (mode_q == MODE_WALK) ? MODE_BIN : mode_e'(mode_q + 2'd1);
`endif
        patLoad_d = (mode_d == MODE_WALK || mode_d == MODE_BOUNCE) ? ONE_HOT0 : '0;
    end

    // Sequencer: a mode press restarts the pattern and beats a simultaneous
    // timer wrap; otherwise a wrap advances one step and raises TICK.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_q    <= MODE_BIN;
            paused_q  <= 1'b0;
            tick_q    <= 1'b0;
            pat_q     <= '0;
            step_q    <= '0;
            pos_q     <= '0;
            presc_q   <= '0;
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
            dirDown_q <= 1'b0;
`endif
        end else begin
            tick_q <= 1'b0;
            if (press_d[BTN_IDX_PAUSE]) begin
                paused_q <= ~paused_q;
            end
            if (press_d[BTN_IDX_MODE]) begin
                mode_q    <= mode_d;
                step_q    <= '0;
                pos_q     <= '0;
                presc_q   <= '0;
                pat_q     <= patLoad_d;
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
                dirDown_q <= 1'b0;
`endif
            end else if (wrap) begin
                step_q    <= step_d;
                pos_q     <= pos_d;
                presc_q   <= '0;
                pat_q     <= patStep_d;
                tick_q    <= 1'b1;
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
                dirDown_q <= dirDown_d;
`endif
            end else if (!paused_q) begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign PAT    = pat_q;
    assign MODE   = mode_q;
    assign PAUSED = paused_q;
    assign TICK   = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed bench for led_pattern_seq with WIDTH=4,
// LOG2DELAY=2, DEBOUNCE_BITS=2. Expectations follow LED_PATTERN_SEQ_BOUNCE_EN.
module tb_led_pattern_seq;

    localparam int W  = 4;
    localparam int LD = 2;
    localparam int DB = 2;

    logic         clock = 1'b0;
    logic         resetN;
    logic         btnMode;
    logic         btnPause;
    logic [W-1:0] pat;
    logic [1:0]   mode;
    logic         paused;
    logic         tick;

    int checkCount = 0;
    int passCount  = 0;
    int expMode    = 0;

    int expGray [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    int expWalk [5] = '{2, 4, 8, 1, 2};
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
    int expMode3Seq [8] = '{2, 4, 8, 4, 2, 1, 2, 4};
    localparam int MODE3_INIT = 1;
`else
    int expMode3Seq [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    localparam int MODE3_INIT = 0;
`endif

    led_pattern_seq #(
        .WIDTH         (W),
        .LOG2DELAY     (LD),
        .DEBOUNCE_BITS (DB)
    ) dut (
        .CLK       (clock),
        .RST_N     (resetN),
        .BTN_MODE  (btnMode),
        .BTN_PAUSE (btnPause),
        .PAT       (pat),
        .MODE      (mode),
        .PAUSED    (paused),
        .TICK      (tick)
    );

    always #5 clock = ~clock;

    function automatic int nextMode(input int m);
`ifdef LED_PATTERN_SEQ_BOUNCE_EN
        return (m + 1) % 4;
`else
        return (m == 2) ? 0 : m + 1;
`endif
    endfunction

    function automatic int initPat(input int m);
        return (m >= 2) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic p, input int hold);
        btnMode  = m;
        btnPause = p;
        stepCycles(hold);
        btnMode  = 1'b0;
        btnPause = 1'b0;
    endtask

    task automatic expectTick(input string tag, input int expPat);
        stepCycles(3);
        checkOutput({tag, "_quiet"}, 32'(tick), 0);
        stepCycles(1);
        checkOutput({tag, "_tick"}, 32'(tick), 1);
        checkOutput({tag, "_pat"}, 32'(pat), expPat);
    endtask

    initial begin
        bit sawTick;
        bit patMoved;
        bit found;
        logic [W-1:0] frozen;

        resetN   = 1'b0;
        btnMode  = 1'b0;
        btnPause = 1'b0;
        stepCycles(3);
        checkOutput("resetPat", 32'(pat), 0);
        checkOutput("resetMode", 32'(mode), 0);
        checkOutput("resetPaused", 32'(paused), 0);
        checkOutput("resetTick", 32'(tick), 0);

        resetN = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            expectTick($sformatf("bin%0d", k), k % 16);
        end
        checkOutput("binMode", 32'(mode), 0);
        checkOutput("binPaused", 32'(paused), 0);

        btnMode = 1'b1;
        stepCycles(5);
        checkOutput("modeBeforeWindow", 32'(mode), 0);
        stepCycles(1);
        expMode = nextMode(expMode);
        checkOutput("grayMode", 32'(mode), expMode);
        checkOutput("grayInitPat", 32'(pat), 0);
        checkOutput("grayChangeTick", 32'(tick), 0);
        stepCycles(4);
        checkOutput("gray0_tick", 32'(tick), 1);
        checkOutput("gray0_pat", 32'(pat), expGray[0]);
        btnMode = 1'b0;
        for (int i = 1; i < 8; i++) begin
            expectTick($sformatf("gray%0d", i), expGray[i]);
        end
        checkOutput("graySingleInc", 32'(mode), expMode);

        applyStimulus(1'b1, 1'b0, 6);
        expMode = nextMode(expMode);
        checkOutput("walkMode", 32'(mode), expMode);
        checkOutput("walkInitPat", 32'(pat), 1);
        checkOutput("walkChangeTick", 32'(tick), 0);
        for (int i = 0; i < 5; i++) begin
            expectTick($sformatf("walk%0d", i), expWalk[i]);
        end

        applyStimulus(1'b1, 1'b0, 6);
        expMode = nextMode(expMode);
        checkOutput("mode3Mode", 32'(mode), expMode);
        checkOutput("mode3InitPat", 32'(pat), MODE3_INIT);
        for (int i = 0; i < 8; i++) begin
            expectTick($sformatf("mode3_%0d", i), expMode3Seq[i]);
        end

        // Press lands exactly on the prescaler wrap edge (8 edges after a tick).
        stepCycles(2);
        applyStimulus(1'b1, 1'b0, 6);
        expMode = nextMode(expMode);
        checkOutput("wrapMode", 32'(mode), expMode);
        checkOutput("wrapPat", 32'(pat), initPat(expMode));
        checkOutput("wrapTick", 32'(tick), 0);
        expectTick("postWrap", 1);

        btnPause = 1'b1;
        stepCycles(3);
        btnPause = 1'b0;
        stepCycles(10);
        checkOutput("glitchPaused", 32'(paused), 0);
        checkOutput("glitchMode", 32'(mode), expMode);

        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("pauseOn", 32'(paused), 1);
        frozen   = pat;
        sawTick  = 1'b0;
        patMoved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            stepCycles(1);
            if (tick) sawTick = 1'b1;
            if (pat !== frozen) patMoved = 1'b1;
        end
        checkOutput("pauseNoTick", 32'(sawTick), 0);
        checkOutput("pauseFrozen", 32'(patMoved), 0);

        applyStimulus(1'b1, 1'b0, 6);
        expMode = nextMode(expMode);
        checkOutput("pausedModeChange", 32'(mode), expMode);
        checkOutput("pausedModePat", 32'(pat), initPat(expMode));
        checkOutput("pausedStill", 32'(paused), 1);
        sawTick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepCycles(1);
            if (tick) sawTick = 1'b1;
        end
        checkOutput("pausedModeNoTick", 32'(sawTick), 0);

        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("pauseOff", 32'(paused), 0);
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found) begin
                stepCycles(1);
                if (tick) found = 1'b1;
            end
        end
        checkOutput("resumeTick", 32'(found), 1);
        checkOutput("resumePat", 32'(pat), (expMode == 2) ? 2 : 1);

        stepCycles(10);
        applyStimulus(1'b1, 1'b1, 6);
        expMode = nextMode(expMode);
        checkOutput("bothMode", 32'(mode), expMode);
        checkOutput("bothPaused", 32'(paused), 1);
        stepCycles(10);
        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("bothUnpause", 32'(paused), 0);

        btnMode = 1'b1;
        stepCycles(4);
        resetN  = 1'b0;
        btnMode = 1'b0;
        stepCycles(1);
        checkOutput("midResetPat", 32'(pat), 0);
        checkOutput("midResetMode", 32'(mode), 0);
        checkOutput("midResetPaused", 32'(paused), 0);
        checkOutput("midResetTick", 32'(tick), 0);
        resetN = 1'b1;
        stepCycles(10);
        checkOutput("noSpuriousMode", 32'(mode), 0);
        checkOutput("noSpuriousPause", 32'(paused), 0);

        resetN  = 1'b0;
        btnMode = 1'b1;
        stepCycles(2);
        resetN = 1'b1;
        stepCycles(5);
        checkOutput("heldBeforeWindow", 32'(mode), 0);
        stepCycles(1);
        checkOutput("heldPressMode", 32'(mode), 1);
        checkOutput("heldPressPat", 32'(pat), 0);
        btnMode = 1'b0;
        stepCycles(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
